score_bcd_converter: RTL and testbench
======================================

// Module: score_bcd_converter
// PURPOSE
//  Sequential binary-to-BCD converter (shift-add-3, one bit per clock) for the Breakout score.
//  Sits between the ball logic's 16-bit curr_score and the HexDriver digit inputs.
//  Converts automatically whenever the score changes, or on an explicit start pulse.
//  Also produces a leading-zero blank mask so the top-level can dark unused HEX digits.
// PARAMETERS
//  BIN_W   16  width of binary score input
//  DIGITS  5   BCD digits produced; must satisfy 10**DIGITS > 2**BIN_W - 1
// PORTS
//  Clk      in   1           system clock (MAX10_CLK1_50)
//  Reset    in   1           synchronous, active-high reset
//  start    in   1           request conversion of bin (pulse or level)
//  bin      in   BIN_W       binary score (curr_score)
//  busy     out  1           conversion in progress
//  done     out  1           one-cycle pulse; bcd/blank updated this cycle
//  bcd      out  4*DIGITS    held result; digit i = bcd[4i+3:4i], digit 0 = ones
//  blank    out  DIGITS      blank[i]=1 iff digit i and all higher digits are 0 (i>0); blank[0]=0 always
// BEHAVIOUR
//  Reset (sync): state=IDLE; busy=0, done=0, bcd=0, blank={DIGITS-1{1'b1}},1'b0; last_bin=0.
//  FSM: IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE: trigger = start | (bin != last_bin). On trigger: sh_bin<=bin, last_bin<=bin,
//     sh_bcd<=0, cnt<=0, state<=SHIFT. busy=0.
//   SHIFT: each cycle, every nibble of sh_bcd >= 5 gets +3 (4-bit, no carry out), then
//     {sh_bcd,sh_bin} shifts left 1. cnt++; after BIN_W shifts state<=DONE. busy=1.
//   DONE: bcd<=sh_bcd, blank<=computed mask, done=1 for exactly this cycle, state<=IDLE. busy=1.
//  Latency: start sampled at edge E0; done and new bcd visible after edge E0+BIN_W+1 (17 for default).
//  bcd/blank change only on the done edge; never show partial results.
//  start or bin change while busy: ignored; bin captured at trigger is converted. After DONE,
//   if bin != last_bin, IDLE retriggers on the next cycle (no lost updates, no queue > 1).
//  start and bin change same cycle: one conversion only.
//  start held high in IDLE: back-to-back conversions, one per BIN_W+2 cycles.
//  Reset mid-conversion: abort immediately, outputs to reset values, no done pulse.
//  Width rule: sh_bcd is 4*DIGITS bits; top nibble never exceeds 9 for legal params.
// STRUCTURE
//  Package breakout_pkg: SCORE_W=16, SCORE_DIGITS=5, typedef enum logic[1:0] {IDLE,SHIFT,DONE} bcd_state_t.
//  One sub-module: bcd_add3 (4-bit comb: out = in>=5 ? in+3 : in), generated DIGITS times.
//  Blank mask computed combinationally from sh_bcd in DONE and registered.
// TESTING
//  1. Reset, bin=0, no start -> bcd=20'h00000, blank=5'b11110, no done pulse.
//  2. bin=1234, start 1 cycle -> done exactly 17 cycles later; bcd=20'h01234, blank=5'b10000.
//  3. bin=65535 -> bcd=20'h65535, blank=5'b00000; busy high for 17 cycles.
//  4. bin 10->99 at cycle 5 of conversion -> first done bcd=20'h00010, second done bcd=20'h00099, 2 done pulses total.
//  5. Reset asserted at cycle 8 of conversion of 500 -> busy=0, bcd=0, no done; new start converts cleanly.
//  6. Random sweep 2000 values vs reference model -> bcd and blank match every done; no done while idle and bin stable.

Source files
------------

// File: rtl/breakout_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : breakout_pkg
//  Purpose  : Shared score widths and converter FSM state type for Breakout.
//  Revision : 1.0 - initial release
// ============================================================================
package breakout_pkg;

    localparam int SCORE_W      = 16;
    localparam int SCORE_DIGITS = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_t;

endpackage
`default_nettype wire

// File: rtl/bcd_add3.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_add3
//  Purpose  : Double-dabble nibble correction, adds 3 to values of 5 or more.
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_add3 (
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib
);

    // Wraps silently for 13..15; those codes never reach here from a valid BCD digit.
    assign o_nib = (i_nib >= 4'd5) ? (i_nib + 4'd3) : i_nib;

endmodule
`default_nettype wire

// File: rtl/score_bcd_converter.sv
`default_nettype none
// ============================================================================
//  Module   : score_bcd_converter
//  Purpose  : Serial shift-add-3 binary to BCD converter for the score display,
//             with a leading-zero blank mask for the HEX digits.
//  Revision : 1.0 - initial release
// ============================================================================
module score_bcd_converter
    import breakout_pkg::*;
#(
    parameter int BIN_W  = SCORE_W,
    parameter int DIGITS = SCORE_DIGITS
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    localparam logic [DIGITS-1:0] c_blank_rst = {{(DIGITS-1){1'b1}}, 1'b0};

    bcd_state_t         r_state;
    bcd_state_t         w_state_next;
    logic [BIN_W-1:0]   r_sh_bin;
    logic [BIN_W-1:0]   r_last_bin;
    logic [BCD_W-1:0]   r_sh_bcd;
    logic [BCD_W-1:0]   w_adj_bcd;
    logic [BCD_W-1:0]   r_bcd;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_done;
    logic [DIGITS-1:0]  r_blank;
    logic [DIGITS-1:0]  w_blank;
    logic               w_trigger;
    logic               w_last_shift;

    assign w_trigger    = start | (bin != r_last_bin);
    assign w_last_shift = (r_cnt == CNT_W'(BIN_W - 1));

    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_add3
            bcd_add3 u_add3 (
                .i_nib (r_sh_bcd[4*i +: 4]),
                .o_nib (w_adj_bcd[4*i +: 4])
            );
        end
    endgenerate

    // A digit is dark only when it and every more significant digit are zero.
    assign w_blank[0] = 1'b0;
    generate
        for (genvar i = 1; i < DIGITS; i++) begin : g_blank
            assign w_blank[i] = (r_sh_bcd[BCD_W-1:4*i] == '0);
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_trigger)    w_state_next = SHIFT;
            SHIFT:   if (w_last_shift) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_sh_bin   <= '0;
            r_sh_bcd   <= '0;
            r_last_bin <= '0;
            r_cnt      <= '0;
            r_done     <= 1'b0;
            r_bcd      <= '0;
            r_blank    <= c_blank_rst;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_trigger) begin
                        r_sh_bin   <= bin;
                        r_last_bin <= bin;
                        r_sh_bcd   <= '0;
                        r_cnt      <= '0;
                    end
                end
                SHIFT: begin
                    {r_sh_bcd, r_sh_bin} <= {w_adj_bcd[BCD_W-2:0], r_sh_bin, 1'b0};
                    r_cnt                <= r_cnt + CNT_W'(1);
                end
                DONE: begin
                    r_bcd   <= r_sh_bcd;
                    r_blank <= w_blank;
                    r_done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy  = (r_state != IDLE);
    assign done  = r_done;
    assign bcd   = r_bcd;
    assign blank = r_blank;

endmodule
`default_nettype wire

// File: tb/tb_score_bcd_converter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_score_bcd_converter
//  Purpose  : Scoreboard bench for score_bcd_converter against a decimal model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_score_bcd_converter;

    localparam int BIN_W  = 16;
    localparam int DIGITS = 5;

    logic        Clk   = 1'b0;
    logic        Reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] bin   = '0;
    logic        busy;
    logic        done;
    logic [19:0] bcd;
    logic [4:0]  blank;

    always #5 Clk = ~Clk;

    score_bcd_converter #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .blank (blank)
    );

    typedef struct packed {
        logic [19:0] bcd;
        logic [4:0]  blank;
        int          due;
    } exp_t;

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;
    int          n_done = 0;
    int          m_cnt  = 0;
    logic [15:0] m_last = '0;
    logic [19:0] held_bcd   = '0;
    logic [4:0]  held_blank = 5'b11110;

    function automatic logic [19:0] ref_bcd(input int v);
        logic [19:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [4:0] ref_blank(input int v);
        logic [4:0] b;
        int p;
        b = '0;
        p = 10;
        for (int i = 1; i < DIGITS; i++) begin
            b[i] = (v < p);
            p = p * 10;
        end
        return b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drives one cycle of inputs and advances the reference model for that edge.
    task automatic step(input bit s, input logic [15:0] b, input bit r = 1'b0);
        exp_t e;
        @(posedge Clk);
        #2;
        start = s;
        bin   = b;
        Reset = r;
        if (r) begin
            q.delete();
            m_cnt  = 0;
            m_last = '0;
        end else if (m_cnt > 0) begin
            m_cnt--;
        end else if (s || (b != m_last)) begin
            m_last  = b;
            e.bcd   = ref_bcd(int'(b));
            e.blank = ref_blank(int'(b));
            e.due   = cyc + 1 + BIN_W + 1;
            q.push_back(e);
            m_cnt = BIN_W + 1;
        end
    endtask

    task automatic monitor();
        exp_t e;
        logic last_rst;
        forever begin
            @(posedge Clk);
            cyc++;
            last_rst = Reset;
            @(negedge Clk);
            if (last_rst) begin
                held_bcd   = '0;
                held_blank = 5'b11110;
                check("reset_done", 32'(done), 32'd0);
                check("reset_busy", 32'(busy), 32'd0);
            end else if (done) begin
                n_done++;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_done: got done=1 expected none (cycle %0d, bcd %0h)", cyc, bcd);
                end else begin
                    e = q.pop_front();
                    check("done_cycle", 32'(cyc), 32'(e.due));
                    held_bcd   = e.bcd;
                    held_blank = e.blank;
                end
            end
            check("bcd", 32'(bcd), 32'(held_bcd));
            check("blank", 32'(blank), 32'(held_blank));
        end
    endtask

    initial begin
        int busy_cnt;
        int d0;
        logic [15:0] v;
        int gap;

        fork
            monitor();
        join_none

        // Reset, then idle with bin=0: no conversion expected.
        repeat (3) step(1'b0, 16'd0, 1'b1);
        repeat (20) step(1'b0, 16'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_ndone", 32'(n_done), 32'd0);

        step(1'b1, 16'd1234);
        repeat (20) step(1'b0, 16'd1234);
        check("bcd_1234", 32'(bcd), 32'h01234);

        step(1'b1, 16'd65535);
        busy_cnt = 0;
        for (int i = 0; i < 25; i++) begin
            step(1'b0, 16'd65535);
            if (busy) busy_cnt++;
        end
        check("busy_cycles", 32'(busy_cnt), 32'd17);
        check("bcd_65535", 32'(bcd), 32'h65535);
        check("blank_65535", 32'(blank), 32'h0);

        // bin change mid-conversion: the original value completes, then the new one.
        d0 = n_done;
        step(1'b1, 16'd10);
        repeat (4) step(1'b0, 16'd10);
        repeat (45) step(1'b0, 16'd99);
        check("retrigger_count", 32'(n_done - d0), 32'd2);
        check("bcd_99", 32'(bcd), 32'h00099);

        // Reset mid-conversion aborts without a done pulse.
        d0 = n_done;
        step(1'b1, 16'd500);
        repeat (7) step(1'b0, 16'd500);
        step(1'b0, 16'd500, 1'b1);
        step(1'b0, 16'd500, 1'b1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_bcd", 32'(bcd), 32'd0);
        check("abort_blank", 32'(blank), 32'(5'b11110));
        check("abort_ndone", 32'(n_done - d0), 32'd0);
        step(1'b1, 16'd500);
        repeat (20) step(1'b0, 16'd500);
        check("bcd_500", 32'(bcd), 32'h00500);

        v = 16'd500;
        for (int i = 0; i < 2000; i++) begin
            v = 16'($urandom_range(0, 65535));
            if (i % 100 == 0) v = 16'd0;
            if (i % 100 == 50) v = 16'hFFFF;
            step($urandom_range(0, 3) == 0, v);
            gap = $urandom_range(0, 20);
            for (int j = 0; j < gap; j++) begin
                step($urandom_range(0, 15) == 0, v);
            end
        end
        repeat (40) step(1'b0, v);
        check("queue_empty", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
